// File: rtl/pwm_pkg.sv
// Shared types and helpers for the pulse width meter.
// Saturating increment is shared by the width counter and the statistics.
package pwm_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int STAT_W_DEF = 16;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/pwm_out_reg.sv
// Single-entry valid/ready result register.
// A result arriving while the entry is held and not drained is dropped.
module pwm_out_reg
  import pwm_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         done,
  input  logic [W-1:0] done_width,
  input  logic         done_sat,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         sat,
  output logic         drop
);

  logic fire;
  logic take;

  assign fire = valid && ready;
  assign take = done && (!valid || ready);
  assign drop = done && valid && !ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      sat   <= 1'b0;
    end else if (take) begin
      valid <= 1'b1;
      data  <= done_width;
      sat   <= done_sat;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high-pulse widths from rising/falling edge strobes
// and keeps pulse count, maximum width and drop statistics.
module pulse_width_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rising_edge,
  input  logic              falling_edge,
  input  logic              clear,
  output logic              width_valid,
  input  logic              width_ready,
  output logic [CNT_W-1:0]  width_data,
  output logic              width_sat,
  output logic [STAT_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0]  max_width,
  output logic [STAT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              sat_flag;
  logic              start;
  logic              step;
  logic              done;
  logic              drop;

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rising_edge)  state_nxt = MEASURE;
      MEASURE: if (falling_edge) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == IDLE) && rising_edge;
    step  = (state == MEASURE) && !falling_edge;
    done  = (state == MEASURE) && falling_edge;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else begin
      unique case (1'b1)
        start: begin
          cnt      <= CNT_W'(1);
          sat_flag <= 1'b0;
        end
        step: begin
          cnt      <= cnt_inc;
          sat_flag <= sat_flag | (cnt_inc == CNT_MAX);
        end
        default: ;
      endcase
    end
  end

  pwm_out_reg #(
    .W (CNT_W)
  ) u_out (
    .clk        (clk),
    .reset_n    (reset_n),
    .done       (done),
    .done_width (cnt),
    .done_sat   (sat_flag),
    .ready      (width_ready),
    .valid      (width_valid),
    .data       (width_data),
    .sat        (width_sat),
    .drop       (drop)
  );

  // clear outranks any statistic update in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
      max_width <= '0;
      drop_cnt  <= '0;
    end else if (clear) begin
      pulse_cnt <= '0;
      max_width <= '0;
      drop_cnt  <= '0;
    end else if (done) begin
      pulse_cnt <= STAT_W'(sat_inc(32'(pulse_cnt), 32'(STAT_MAX)));
      if (cnt > max_width) max_width <= cnt;
      if (drop)
        drop_cnt <= STAT_W'(sat_inc(32'(drop_cnt), 32'(STAT_MAX)));
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: directed scenarios plus random
// stimulus against a cycle-timestamp reference model.
module tb_pulse_width_meter;

  localparam int CW   = 4;
  localparam int SW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n     = 1'b0;
  logic          sig_in      = 1'b0;
  logic          sig_q       = 1'b0;
  logic          clear       = 1'b0;
  logic          width_ready = 1'b0;
  logic          rising_edge;
  logic          falling_edge;
  logic          width_valid;
  logic [CW-1:0] width_data;
  logic          width_sat;
  logic [SW-1:0] pulse_cnt;
  logic [CW-1:0] max_width;
  logic [SW-1:0] drop_cnt;

  always_ff @(posedge clk) sig_q <= sig_in;
  assign rising_edge  = sig_in & ~sig_q;
  assign falling_edge = ~sig_in & sig_q;

  pulse_width_meter #(
    .CNT_W  (CW),
    .STAT_W (SW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rising_edge  (rising_edge),
    .falling_edge (falling_edge),
    .clear        (clear),
    .width_valid  (width_valid),
    .width_ready  (width_ready),
    .width_data   (width_data),
    .width_sat    (width_sat),
    .pulse_cnt    (pulse_cnt),
    .max_width    (max_width),
    .drop_cnt     (drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit m_meas, m_prev, m_valid, m_sat;
  int m_cyc, m_start, m_data;
  int m_pcnt, m_max, m_dcnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Widths are cycle-stamp differences between the sampled edges.
  task automatic model_step();
    bit rise, fall, done, drop;
    int w;
    if (!reset_n) begin
      m_meas = 0; m_valid = 0; m_sat = 0; m_data = 0;
      m_pcnt = 0; m_max = 0; m_dcnt = 0;
      m_prev = sig_in;
      return;
    end
    rise = sig_in && !m_prev;
    fall = !sig_in && m_prev;
    m_prev = sig_in;
    m_cyc++;
    done = 0; drop = 0; w = 0;
    if (m_meas) begin
      if (fall) begin
        done = 1;
        w = m_cyc - m_start;
        m_meas = 0;
      end
    end else if (rise) begin
      m_meas = 1;
      m_start = m_cyc;
    end
    if (done) begin
      if (!m_valid || width_ready) begin
        m_valid = 1;
        m_data = (w > CMAX) ? CMAX : w;
        m_sat = (w >= CMAX);
      end else begin
        drop = 1;
      end
    end else if (m_valid && width_ready) begin
      m_valid = 0;
    end
    if (clear) begin
      m_pcnt = 0; m_max = 0; m_dcnt = 0;
    end else if (done) begin
      if (m_pcnt < SMAX) m_pcnt++;
      if (((w > CMAX) ? CMAX : w) > m_max) m_max = (w > CMAX) ? CMAX : w;
      if (drop && m_dcnt < SMAX) m_dcnt++;
    end
  endtask

  task automatic check_all();
    chk("valid", width_valid, m_valid);
    if (m_valid || !reset_n) begin
      chk("data", width_data, m_data);
      chk("sat", width_sat, m_sat);
    end
    chk("pulse_cnt", pulse_cnt, m_pcnt);
    chk("max_width", max_width, m_max);
    chk("drop_cnt", drop_cnt, m_dcnt);
  endtask

  task automatic tick(input bit i, input bit r,
                      input bit c, input bit n);
    sig_in = i;
    width_ready = r;
    clear = c;
    reset_n = n;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse(input int n, input bit r_hi,
                       input bit r_fall, input bit c_fall);
    repeat (n) tick(1, r_hi, 0, 1);
    tick(0, r_fall, c_fall, 1);
  endtask

  task automatic gap(input int g, input bit r);
    repeat (g) tick(0, r, 0, 1);
  endtask

  initial begin
    repeat (3) tick(0, 0, 0, 0);
    chk("rst_valid", width_valid, 0);
    chk("rst_pcnt", pulse_cnt, 0);

    for (int n = 1; n <= 10; n++) begin
      pulse(n, 1, 1, 0);
      chk("s1_valid", width_valid, 1);
      chk("s1_data", width_data, n);
      chk("s1_sat", width_sat, 0);
      gap(3, 1);
    end
    chk("s1_pcnt", pulse_cnt, 10);
    chk("s1_max", max_width, 10);
    chk("s1_drop", drop_cnt, 0);
    tick(0, 1, 1, 1);

    pulse(3, 0, 0, 0);
    gap(2, 0);
    pulse(5, 0, 0, 0);
    chk("s2_valid", width_valid, 1);
    chk("s2_data", width_data, 3);
    chk("s2_drop", drop_cnt, 1);
    chk("s2_pcnt", pulse_cnt, 2);
    chk("s2_max", max_width, 5);
    tick(0, 1, 0, 1);
    chk("s2_drain", width_valid, 0);
    tick(0, 1, 1, 1);

    pulse(20, 1, 1, 0);
    chk("s3_data", width_data, CMAX);
    chk("s3_sat", width_sat, 1);
    gap(2, 1);
    pulse(2, 1, 1, 0);
    chk("s3_data2", width_data, 2);
    chk("s3_sat2", width_sat, 0);
    gap(2, 1);

    repeat (2) tick(1, 1, 0, 0);
    repeat (3) tick(1, 1, 0, 1);
    tick(0, 1, 0, 1);
    chk("s4_ignored", width_valid, 0);
    gap(2, 1);
    pulse(4, 1, 1, 0);
    chk("s4_data", width_data, 4);
    gap(2, 1);
    tick(0, 1, 1, 1);

    pulse(2, 0, 0, 0);
    gap(2, 0);
    pulse(7, 0, 1, 0);
    chk("s5_valid", width_valid, 1);
    chk("s5_data", width_data, 7);
    chk("s5_drop", drop_cnt, 0);
    gap(2, 1);

    pulse(9, 1, 1, 1);
    chk("s6_pcnt", pulse_cnt, 0);
    chk("s6_max", max_width, 0);
    chk("s6_valid", width_valid, 1);
    chk("s6_data", width_data, 9);
    gap(2, 1);
    pulse(3, 0, 0, 0);
    repeat (3) tick(1, 0, 0, 1);
    tick(1, 0, 0, 0);
    chk("s7_valid", width_valid, 0);
    chk("s7_pcnt", pulse_cnt, 0);
    chk("s7_max", max_width, 0);
    tick(0, 1, 0, 0);
    repeat (3) tick(0, 1, 0, 1);
    chk("s7_none", width_valid, 0);

    for (int k = 0; k < 1500; k++) begin
      bit i;
      i = sig_in;
      if ($urandom_range(0, 5) == 0) i = ~i;
      tick(i, $urandom_range(0, 2) != 0,
           $urandom_range(0, 200) == 0,
           $urandom_range(0, 400) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
